// File: rtl/reg_file_mp.sv
// Clocked integer register file: two combinational read ports, two write ports
// (W0 = ALU writeback, W1 = load writeback) and a per-register load-busy scoreboard.
module reg_file_mp #(
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   Rs1_addr,
    input  logic [AW-1:0]   Rs2_addr,
    output logic [XLEN-1:0] Rs1_data,
    output logic [XLEN-1:0] Rs2_data,
    input  logic            W0en,
    input  logic [AW-1:0]   W0_addr,
    input  logic [XLEN-1:0] W0_data,
    input  logic            W1en,
    input  logic [AW-1:0]   W1_addr,
    input  logic [XLEN-1:0] W1_data,
    input  logic            busy_set,
    input  logic [AW-1:0]   busy_addr,
    output logic            Rs1_busy,
    output logic            Rs2_busy
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            w0_we;
    logic            w1_we;
    logic            bs_we;

    logic [AW-1:0]   rs_addr [2];
    logic [XLEN-1:0] rs_data [2];
    logic            rs_busy [2];

    // Register 0 never accepts writes or busy marks when it is hardwired.
    always_comb begin
        w0_we = W0en && !(ZERO_REG && (W0_addr == '0));
        w1_we = W1en && !(ZERO_REG && (W1_addr == '0));
        bs_we = busy_set && !(ZERO_REG && (busy_addr == '0));
    end

    // W1 is applied first so a same-address W0 write overrides it.
    always_comb begin
        regs_d = regs_q;
        if (w1_we) regs_d[W1_addr] = W1_data;
        if (w0_we) regs_d[W0_addr] = W0_data;
    end

    // Clear before set: a load issued to a register whose previous load completes now stays busy.
    always_comb begin
        busy_d = busy_q;
        if (W1en)  busy_d[W1_addr]   = 1'b0;
        if (bs_we) busy_d[busy_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign rs_addr[0] = Rs1_addr;
    assign rs_addr[1] = Rs2_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rs_data[p] = regs_q[rs_addr[p]];
            rs_busy[p] = busy_q[rs_addr[p]];
            if (BYPASS) begin
                if (W0en && (W0_addr == rs_addr[p])) rs_data[p] = W0_data;
                else if (W1en && (W1_addr == rs_addr[p])) rs_data[p] = W1_data;
                if (W1en && (W1_addr == rs_addr[p])) rs_busy[p] = 1'b0;
            end
            if (!rst_n || (ZERO_REG && (rs_addr[p] == '0))) begin
                rs_data[p] = '0;
                rs_busy[p] = 1'b0;
            end
        end
    end

    assign Rs1_data = rs_data[0];
    assign Rs2_data = rs_data[1];
    assign Rs1_busy = rs_busy[0];
    assign Rs2_busy = rs_busy[1];

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: instance a uses BYPASS=1/ZERO_REG=1, instance b uses BYPASS=0/ZERO_REG=0;
// both see the same stimulus and are compared against a scoreboard fed by a reference model.
module tb_reg_file_mp;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   Rs1_addr, Rs2_addr;
    logic            W0en, W1en, busy_set;
    logic [AW-1:0]   W0_addr, W1_addr, busy_addr;
    logic [XLEN-1:0] W0_data, W1_data;

    logic [XLEN-1:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
    logic            a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy;

    logic [XLEN-1:0] mem_a [NREG];
    logic [XLEN-1:0] mem_b [NREG];
    logic [NREG-1:0] busy_a, busy_b;

    logic [2*XLEN+1:0] exp_a_q[$];
    logic [2*XLEN+1:0] exp_b_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reg_file_mp u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .Rs1_addr(Rs1_addr), .Rs2_addr(Rs2_addr),
        .Rs1_data(a_rs1_data), .Rs2_data(a_rs2_data),
        .W0en(W0en), .W0_addr(W0_addr), .W0_data(W0_data),
        .W1en(W1en), .W1_addr(W1_addr), .W1_data(W1_data),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .Rs1_busy(a_rs1_busy), .Rs2_busy(a_rs2_busy)
    );

    reg_file_mp #(.BYPASS(1'b0), .ZERO_REG(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .Rs1_addr(Rs1_addr), .Rs2_addr(Rs2_addr),
        .Rs1_data(b_rs1_data), .Rs2_data(b_rs2_data),
        .W0en(W0en), .W0_addr(W0_addr), .W0_data(W0_data),
        .W1en(W1en), .W1_addr(W1_addr), .W1_data(W1_data),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .Rs1_busy(b_rs1_busy), .Rs2_busy(b_rs2_busy)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [XLEN-1:0] model_rd(input bit is_a, input logic [AW-1:0] a);
        if (!rst_n) return '0;
        if (!is_a) return mem_b[a];
        if (a == '0) return '0;
        if (W0en && W0_addr == a) return W0_data;
        if (W1en && W1_addr == a) return W1_data;
        return mem_a[a];
    endfunction

    function automatic logic model_busy(input bit is_a, input logic [AW-1:0] a);
        if (!rst_n) return 1'b0;
        if (!is_a) return busy_b[a];
        return (a != '0) && busy_a[a] && !(W1en && W1_addr == a);
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_a[i] = '0;
                mem_b[i] = '0;
            end
            busy_a = '0;
            busy_b = '0;
        end else begin
            if (W1en && W1_addr != '0) mem_a[W1_addr] = W1_data;
            if (W0en && W0_addr != '0) mem_a[W0_addr] = W0_data;
            if (W1en) mem_b[W1_addr] = W1_data;
            if (W0en) mem_b[W0_addr] = W0_data;
            if (W1en) begin
                busy_a[W1_addr] = 1'b0;
                busy_b[W1_addr] = 1'b0;
            end
            if (busy_set) begin
                if (busy_addr != '0) busy_a[busy_addr] = 1'b1;
                busy_b[busy_addr] = 1'b1;
            end
        end
    endtask

    // One clock: drive, push expectations, sample mid-cycle, then let the edge update the model.
    task automatic cycle(input string tag,
                         input logic w0e, input logic [AW-1:0] w0a, input logic [XLEN-1:0] w0d,
                         input logic w1e, input logic [AW-1:0] w1a, input logic [XLEN-1:0] w1d,
                         input logic bs, input logic [AW-1:0] ba,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        logic [2*XLEN+1:0] e;
        W0en = w0e; W0_addr = w0a; W0_data = w0d;
        W1en = w1e; W1_addr = w1a; W1_data = w1d;
        busy_set = bs; busy_addr = ba;
        Rs1_addr = r1; Rs2_addr = r2;
        exp_a_q.push_back({model_rd(1'b1, r1), model_rd(1'b1, r2), model_busy(1'b1, r1), model_busy(1'b1, r2)});
        exp_b_q.push_back({model_rd(1'b0, r1), model_rd(1'b0, r2), model_busy(1'b0, r1), model_busy(1'b0, r2)});
        #2;
        e = exp_a_q.pop_front();
        chk({tag, "/a_rs1_data"}, a_rs1_data, e[2*XLEN+1 -: XLEN]);
        chk({tag, "/a_rs2_data"}, a_rs2_data, e[XLEN+1 -: XLEN]);
        chk({tag, "/a_rs1_busy"}, {63'd0, a_rs1_busy}, {63'd0, e[1]});
        chk({tag, "/a_rs2_busy"}, {63'd0, a_rs2_busy}, {63'd0, e[0]});
        e = exp_b_q.pop_front();
        chk({tag, "/b_rs1_data"}, b_rs1_data, e[2*XLEN+1 -: XLEN]);
        chk({tag, "/b_rs2_data"}, b_rs2_data, e[XLEN+1 -: XLEN]);
        chk({tag, "/b_rs1_busy"}, {63'd0, b_rs1_busy}, {63'd0, e[1]});
        chk({tag, "/b_rs2_busy"}, {63'd0, b_rs2_busy}, {63'd0, e[0]});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic read(input string tag, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        cycle(tag, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, r1, r2);
    endtask

    initial begin
        rst_n = 1'b0;
        W0en = 1'b0; W0_addr = '0; W0_data = '0;
        W1en = 1'b0; W1_addr = '0; W1_data = '0;
        busy_set = 1'b0; busy_addr = '0;
        Rs1_addr = '0; Rs2_addr = '0;
        for (int i = 0; i < NREG; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        busy_a = '0;
        busy_b = '0;
        repeat (2) @(posedge clk);
        #1;

        // Held in reset: writes and busy_set must not land, outputs read 0.
        cycle("in_reset", 1'b1, 5'd5, 64'hAA, 1'b1, 5'd6, 64'hBB, 1'b1, 5'd5, 5'd5, 5'd6);
        rst_n = 1'b1;
        for (int i = 0; i < NREG; i += 2) read("post_reset", AW'(i), AW'(i + 1));

        // Both write ports, then read back.
        cycle("wr_both", 1'b1, 5'd3, 64'h3, 1'b1, 5'd7, 64'h456701023D2, 1'b0, '0, 5'd3, 5'd7);
        read("rd_both", 5'd3, 5'd7);

        // Same-cycle bypass on W0.
        cycle("bypass_w0", 1'b1, 5'd10, 64'hFFF, 1'b0, '0, '0, 1'b0, '0, 5'd10, 5'd3);
        read("bypass_after", 5'd10, 5'd3);

        // W0/W1 conflict on a busy register.
        cycle("mark_x4", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd4, 5'd4, 5'd4);
        read("x4_busy", 5'd4, 5'd7);
        cycle("conflict", 1'b1, 5'd4, 64'h7, 1'b1, 5'd4, 64'h9, 1'b0, '0, 5'd4, 5'd4);
        read("conflict_after", 5'd4, 5'd4);

        // Scoreboard set, then clear+set on the same cycle.
        cycle("mark_x25", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd25, 5'd25, 5'd24);
        read("x25_busy", 5'd25, 5'd24);
        cycle("clr_set_x25", 1'b0, '0, '0, 1'b1, 5'd25, 64'h5, 1'b1, 5'd25, 5'd25, 5'd25);
        read("x25_after", 5'd25, 5'd25);

        // Register 0.
        cycle("zero_wr", 1'b1, 5'd0, 64'h1234, 1'b0, '0, '0, 1'b1, 5'd0, 5'd0, 5'd0);
        read("zero_after", 5'd0, 5'd0);
        cycle("zero_w1", 1'b0, '0, '0, 1'b1, 5'd0, 64'h77, 1'b0, '0, 5'd0, 5'd1);
        read("zero_w1_after", 5'd0, 5'd1);

        // Reset asserted mid-operation.
        cycle("pre_rst_wr", 1'b1, 5'd5, 64'h55, 1'b0, '0, '0, 1'b1, 5'd9, 5'd5, 5'd9);
        read("pre_rst_rd", 5'd5, 5'd9);
        rst_n = 1'b0;
        cycle("mid_reset", 1'b1, 5'd5, 64'hAA, 1'b0, '0, '0, 1'b1, 5'd5, 5'd5, 5'd9);
        rst_n = 1'b1;
        read("after_reset", 5'd5, 5'd9);
        read("after_reset2", 5'd3, 5'd25);

        // Random traffic over a narrow address window to force collisions.
        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] hi;
            hi = (n % 4 == 0) ? AW'(NREG - 1) : AW'(7);
            cycle("rand",
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, hi)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, hi)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, hi)),
                  AW'($urandom_range(0, hi)), AW'($urandom_range(0, hi)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
